pipe_tracker: RTL and testbench
===============================

Name: pipe_tracker

Overview:
- Parametrised, synthesizable instruction-occupancy tracker for an N-stage in-order pipeline. Successor to the testbench-only per-stage ID tracker.
- Assigns a tag to every fetched instruction and shifts tag, valid, fetch cycle and stall count through a shadow pipeline that obeys the core's stall and flush rules.
- On retire, reports latency, stall cycles and running statistics.
- Sits beside the CPU core; consumed by the Verification_Unit display logic and by performance counters.

Parameters:
- STAGES, 5, number of pipeline stages (2..16); stage 0 = fetch, stage STAGES-1 = write-back.
- TAG_W, 8, instruction tag width; tags wrap mod 2^TAG_W.
- CYC_W, 16, width of cycle counter and fetch-cycle stamps.
- STALL_DEPTH, 2, stages 0..STALL_DEPTH-1 freeze on stall (1..STAGES-1).
- FLUSH_DEPTH, 2, stages 0..FLUSH_DEPTH-1 squashed on flush (1..STAGES-1).
- SCNT_W, 8, per-instruction stall counter width; saturates.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- fetch_valid  in  1  a real instruction is fetched this cycle.
- stall  in  1  freeze front stages, bubble into stage STALL_DEPTH.
- flush  in  1  squash front stages.
- stage_valid  out  STAGES  per-stage occupancy.
- stage_tag  out  STAGES*TAG_W  per-stage tag; stage i at bits [i*TAG_W +: TAG_W].
- retire_valid  out  1  = stage_valid[STAGES-1].
- retire_tag  out  TAG_W  tag in last stage.
- retire_latency  out  CYC_W  cycle_count - fetch_cycle of last stage, mod 2^CYC_W.
- retire_stalls  out  SCNT_W  stall cycles accumulated by last-stage instruction.
- cycle_count  out  CYC_W  free-running cycle counter.
- retired_count  out  32  retired instructions.
- flushed_count  out  32  valid entries squashed.

Behaviour:
- Reset (synchronous): all stage_valid=0; tag, fetch_cycle and stall_cnt=0; next_tag=0; cycle_count=0; retired_count=0; flushed_count=0. Reset mid-operation discards all in-flight entries with no retire and no flush accounting.
- Each non-reset edge: cycle_count++ (wraps).
- Per-stage next-state, in priority order:
  - flush and i<FLUSH_DEPTH: valid<=0.
  - stall and i<STALL_DEPTH: hold contents; if valid, stall_cnt++ (saturating at 2^SCNT_W-1).
  - stall and i==STALL_DEPTH: valid<=0 (bubble).
  - i==0, otherwise: valid<=fetch_valid; tag<=next_tag; fetch_cycle<=cycle_count (pre-increment value); stall_cnt<=0.
  - else: copy stage i-1.
- next_tag increments only when stage 0 loads a valid entry, i.e. fetch_valid & !stall & !flush. Squashed tags are consumed, never reused.
- flushed_count += popcount of valid entries in stages 0..FLUSH_DEPTH-1 when flush=1. An entry flushed while stalled counts once, and its stall_cnt is discarded.
- Stall and flush in the same cycle:
  - flush wins for i<FLUSH_DEPTH.
  - Stages FLUSH_DEPTH..STALL_DEPTH-1, if any, hold.
  - Bubble still enters stage STALL_DEPTH.
- Retire outputs are combinational from the last-stage registers. retired_count++ on every edge where retire_valid=1. The last stage always drains regardless of stall, which is legal since STALL_DEPTH<STAGES.
- No-stall latency = STAGES: the entry loads at edge k with stamp c, reaches the last stage at edge k+STAGES-1, when cycle_count = c+STAGES.
- The 32-bit statistics counters wrap silently.
- Parameter violations (e.g. STALL_DEPTH>=STAGES) are fatal via an elaboration-time check.

Test Plan (defaults unless stated):
- Release reset, hold fetch_valid=1 → stage_valid fills 1,3,7,15,31. First retire: tag 0, latency 5, stalls 0. Then one retire per cycle with consecutive tags.
- Steady stream; assert stall for 2 cycles while tag 5 is in stage 1 and tag 6 in stage 0 → two bubbles retire after tag 4. Tag 5 retires with stalls=2, latency=7; tag 6 likewise.
- Full pipe; pulse flush 1 cycle → stages 0,1 cleared, flushed_count=2, next two retire slots empty. The next fetched instruction's tag = last consumed tag +1, skipping nothing.
- TAG_W=3; fetch 10 instructions → retire tags 0..7,0,1; retired_count=10.
- Assert stall and flush together with tags 3 and 4 in stages 0,1 → both squashed, flushed_count+=2, no stall accounting. Stage 2 gets a bubble; stage 3 advances normally.
- Mid-stream rst=1 for one cycle → all stage_valid=0, counters 0. First post-reset fetch gets tag 0, latency 5.

Source files
------------

// File: rtl/pipe_tracker.sv
// Shadow occupancy tracker for an N-stage in-order pipeline: tags each fetch,
// follows it through stall/flush, and reports latency and stall cycles on retire.
module pipe_tracker #(
    parameter int STAGES      = 5,
    parameter int TAG_W       = 8,
    parameter int CYC_W       = 16,
    parameter int STALL_DEPTH = 2,
    parameter int FLUSH_DEPTH = 2,
    parameter int SCNT_W      = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      fetch_valid,
    input  logic                      stall,
    input  logic                      flush,
    output logic [STAGES-1:0]         stage_valid,
    output logic [STAGES*TAG_W-1:0]   stage_tag,
    output logic                      retire_valid,
    output logic [TAG_W-1:0]          retire_tag,
    output logic [CYC_W-1:0]          retire_latency,
    output logic [SCNT_W-1:0]         retire_stalls,
    output logic [CYC_W-1:0]          cycle_count,
    output logic [31:0]               retired_count,
    output logic [31:0]               flushed_count
);
    localparam int LAST = STAGES - 1;
    localparam logic [SCNT_W-1:0] SCNT_MAX = '1;

    if (STAGES < 2 || STAGES > 16 || STALL_DEPTH < 1 || STALL_DEPTH >= STAGES ||
        FLUSH_DEPTH < 1 || FLUSH_DEPTH >= STAGES) begin : g_param_check
        $fatal(1, "pipe_tracker: illegal parameter combination");
    end

    logic [STAGES-1:0] valid_q, valid_d;
    logic [TAG_W-1:0]  tag_q  [STAGES];
    logic [TAG_W-1:0]  tag_d  [STAGES];
    logic [CYC_W-1:0]  fc_q   [STAGES];
    logic [CYC_W-1:0]  fc_d   [STAGES];
    logic [SCNT_W-1:0] scnt_q [STAGES];
    logic [SCNT_W-1:0] scnt_d [STAGES];
    logic [TAG_W-1:0]  next_tag_q;
    logic [CYC_W-1:0]  cycle_q;
    logic [31:0]       retired_q, flushed_q, flush_pop;
    logic              load_fetch;

    // A tag is consumed only when stage 0 actually captures a real fetch.
    assign load_fetch = fetch_valid & ~stall & ~flush;

    always_comb begin
        // NOTE: every stage field defaults to its held value first, so no path
        // through the priority chain below can leave a latch behind.
        valid_d = valid_q;
        tag_d   = tag_q;
        fc_d    = fc_q;
        scnt_d  = scnt_q;

        // Stage 0 is always inside both the flush and the stall windows.
        if (flush) begin
            valid_d[0] = 1'b0;
        end else if (stall) begin
            if (valid_q[0] && scnt_q[0] != SCNT_MAX) scnt_d[0] = scnt_q[0] + 1'b1;
        end else begin
            valid_d[0] = fetch_valid;
            tag_d[0]   = next_tag_q;
            fc_d[0]    = cycle_q;
            scnt_d[0]  = '0;
        end

        for (int i = 1; i < STAGES; i++) begin
            if (flush && i < FLUSH_DEPTH) begin
                valid_d[i] = 1'b0;
            end else if (stall && i < STALL_DEPTH) begin
                if (valid_q[i] && scnt_q[i] != SCNT_MAX) scnt_d[i] = scnt_q[i] + 1'b1;
            end else if (stall && i == STALL_DEPTH) begin
                valid_d[i] = 1'b0;
            end else begin
                valid_d[i] = valid_q[i-1];
                tag_d[i]   = tag_q[i-1];
                fc_d[i]    = fc_q[i-1];
                scnt_d[i]  = scnt_q[i-1];
            end
        end
    end

    always_comb begin
        flush_pop = '0;
        if (flush) begin
            for (int i = 0; i < FLUSH_DEPTH; i++) flush_pop = flush_pop + 32'(valid_q[i]);
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // register samples pre-edge values regardless of statement order.
        if (rst) begin
            valid_q    <= '0;
            next_tag_q <= '0;
            cycle_q    <= '0;
            retired_q  <= '0;
            flushed_q  <= '0;
            // NOTE: the per-stage arrays are a handful of flops, not a RAM, so
            // clearing them in reset costs nothing and keeps outputs defined.
            for (int i = 0; i < STAGES; i++) begin
                tag_q[i]  <= '0;
                fc_q[i]   <= '0;
                scnt_q[i] <= '0;
            end
        end else begin
            valid_q    <= valid_d;
            tag_q      <= tag_d;
            fc_q       <= fc_d;
            scnt_q     <= scnt_d;
            next_tag_q <= next_tag_q + TAG_W'(load_fetch);
            cycle_q    <= cycle_q + 1'b1;
            retired_q  <= retired_q + 32'(valid_q[LAST]);
            flushed_q  <= flushed_q + flush_pop;
        end
    end

    for (genvar i = 0; i < STAGES; i++) begin : g_tag_out
        assign stage_tag[i*TAG_W +: TAG_W] = tag_q[i];
    end

    assign stage_valid    = valid_q;
    assign retire_valid   = valid_q[LAST];
    assign retire_tag     = tag_q[LAST];
    assign retire_latency = cycle_q - fc_q[LAST];
    assign retire_stalls  = scnt_q[LAST];
    assign cycle_count    = cycle_q;
    assign retired_count  = retired_q;
    assign flushed_count  = flushed_q;
endmodule

// File: tb/tb_pipe_tracker.sv
// Bench for pipe_tracker: directed vector table, hand sequences for the
// stall/flush/reset corners, then random traffic against an entry-level model.
module tb_pipe_tracker;
    localparam int STAGES = 5;
    localparam int LAST   = STAGES - 1;
    localparam int SD     = 2;
    localparam int FD     = 2;

    logic clk, rst, fetch_valid, stall, flush;

    logic [STAGES-1:0]   stage_valid;
    logic [STAGES*8-1:0] stage_tag;
    logic                retire_valid;
    logic [7:0]          retire_tag;
    logic [15:0]         retire_latency, cycle_count;
    logic [7:0]          retire_stalls;
    logic [31:0]         retired_count, flushed_count;

    logic [STAGES-1:0]   s_valid3;
    logic [STAGES*3-1:0] s_tag3;
    logic                r_valid3;
    logic [2:0]          r_tag3;
    logic [15:0]         r_lat3, cyc3;
    logic [1:0]          r_stl3;
    logic [31:0]         ret3, fl3;

    pipe_tracker dut (
        .clk(clk), .rst(rst), .fetch_valid(fetch_valid), .stall(stall), .flush(flush),
        .stage_valid(stage_valid), .stage_tag(stage_tag), .retire_valid(retire_valid),
        .retire_tag(retire_tag), .retire_latency(retire_latency), .retire_stalls(retire_stalls),
        .cycle_count(cycle_count), .retired_count(retired_count), .flushed_count(flushed_count)
    );

    pipe_tracker #(.TAG_W(3), .SCNT_W(2)) dut3 (
        .clk(clk), .rst(rst), .fetch_valid(fetch_valid), .stall(stall), .flush(flush),
        .stage_valid(s_valid3), .stage_tag(s_tag3), .retire_valid(r_valid3),
        .retire_tag(r_tag3), .retire_latency(r_lat3), .retire_stalls(r_stl3),
        .cycle_count(cyc3), .retired_count(ret3), .flushed_count(fl3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference model: each in-flight instruction is a record with an unbounded
    // tag, fetch stamp and stall count; hardware widths are applied only on compare.
    typedef struct {
        bit v;
        int tag;
        int fc;
        int sc;
    } entry_t;

    entry_t m[STAGES];
    int m_next_tag, m_cycle, m_retired, m_flushed;

    function automatic int min_i(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    task automatic model_step(input bit r, input bit fv, input bit st, input bit fl);
        entry_t nxt[STAGES];
        if (r) begin
            foreach (m[i]) m[i] = '{0, 0, 0, 0};
            m_next_tag = 0; m_cycle = 0; m_retired = 0; m_flushed = 0;
            return;
        end
        if (m[LAST].v) m_retired++;
        if (fl) for (int i = 0; i < FD; i++) if (m[i].v) m_flushed++;
        for (int i = 0; i < STAGES; i++) begin
            nxt[i] = m[i];
            if (fl && i < FD)        nxt[i].v = 0;
            else if (st && i < SD)   begin if (m[i].v) nxt[i].sc = m[i].sc + 1; end
            else if (st && i == SD)  nxt[i].v = 0;
            else if (i == 0)         nxt[i] = '{fv, m_next_tag, m_cycle, 0};
            else                     nxt[i] = m[i-1];
        end
        if (fv && !st && !fl) m_next_tag++;
        m_cycle++;
        m = nxt;
    endtask

    task automatic compare_model();
        logic [STAGES-1:0] ev;
        for (int i = 0; i < STAGES; i++) ev[i] = m[i].v;
        check("m_stage_valid", stage_valid, ev);
        check("m3_stage_valid", s_valid3, ev);
        for (int i = 0; i < STAGES; i++) begin
            if (m[i].v) begin
                check("m_stage_tag", stage_tag[i*8 +: 8], m[i].tag % 256);
                check("m3_stage_tag", s_tag3[i*3 +: 3], m[i].tag % 8);
            end
        end
        check("m_retire_valid", retire_valid, m[LAST].v);
        if (m[LAST].v) begin
            check("m_retire_tag", retire_tag, m[LAST].tag % 256);
            check("m_latency", retire_latency, (m_cycle - m[LAST].fc) % 65536);
            check("m_stalls", retire_stalls, min_i(m[LAST].sc, 255));
            check("m3_retire_tag", r_tag3, m[LAST].tag % 8);
            check("m3_latency", r_lat3, (m_cycle - m[LAST].fc) % 65536);
            check("m3_stalls", r_stl3, min_i(m[LAST].sc, 3));
        end
        check("m_cycle", cycle_count, m_cycle % 65536);
        check("m_retired", retired_count, m_retired);
        check("m_flushed", flushed_count, m_flushed);
        check("m3_retired", ret3, m_retired);
    endtask

    // Inputs change 1 time unit after an edge; outputs are sampled at the same point.
    task automatic step(input bit r, input bit fv, input bit st, input bit fl);
        rst = r; fetch_valid = fv; stall = st; flush = fl;
        @(posedge clk);
        #1;
        model_step(r, fv, st, fl);
        compare_model();
    endtask

    typedef struct {
        bit fv, st, fl;
        logic [4:0] ev;
        bit erv;
        int etag, elat, estl, eret, efl;
    } vec_t;

    vec_t vt[$];

    initial begin
        bit found;
        rst = 1'b1; fetch_valid = 1'b0; stall = 1'b0; flush = 1'b0;

        // Fill, two-cycle stall with tags 5/6 in stages 1/0, then a flush of a full pipe.
        vt.push_back('{1,0,0, 5'd1,  0, 0, 0, 0, 0, 0});
        vt.push_back('{1,0,0, 5'd3,  0, 0, 0, 0, 0, 0});
        vt.push_back('{1,0,0, 5'd7,  0, 0, 0, 0, 0, 0});
        vt.push_back('{1,0,0, 5'd15, 0, 0, 0, 0, 0, 0});
        vt.push_back('{1,0,0, 5'd31, 1, 0, 5, 0, 0, 0});
        vt.push_back('{1,0,0, 5'd31, 1, 1, 5, 0, 1, 0});
        vt.push_back('{1,0,0, 5'd31, 1, 2, 5, 0, 2, 0});
        vt.push_back('{1,1,0, 5'd27, 1, 3, 5, 0, 3, 0});
        vt.push_back('{1,1,0, 5'd19, 1, 4, 5, 0, 4, 0});
        vt.push_back('{1,0,0, 5'd7,  0, 0, 0, 0, 5, 0});
        vt.push_back('{1,0,0, 5'd15, 0, 0, 0, 0, 5, 0});
        vt.push_back('{1,0,0, 5'd31, 1, 5, 7, 2, 5, 0});
        vt.push_back('{1,0,0, 5'd31, 1, 6, 7, 2, 6, 0});
        vt.push_back('{1,0,1, 5'd28, 1, 7, 5, 0, 7, 2});
        vt.push_back('{1,0,0, 5'd25, 1, 8, 5, 0, 8, 2});
        vt.push_back('{1,0,0, 5'd19, 1, 9, 5, 0, 9, 2});
        vt.push_back('{1,0,0, 5'd7,  0, 0, 0, 0, 10, 2});
        vt.push_back('{1,0,0, 5'd15, 0, 0, 0, 0, 10, 2});
        vt.push_back('{1,0,0, 5'd31, 1, 11, 5, 0, 10, 2});

        step(1, 0, 0, 0);
        check("reset_valid", stage_valid, 0);
        check("reset_cycle", cycle_count, 0);
        check("reset_retired", retired_count, 0);
        check("reset_flushed", flushed_count, 0);

        foreach (vt[k]) begin
            step(0, vt[k].fv, vt[k].st, vt[k].fl);
            check("vec_valid", stage_valid, vt[k].ev);
            check("vec_retire_valid", retire_valid, vt[k].erv);
            if (vt[k].erv) begin
                check("vec_retire_tag", retire_tag, vt[k].etag);
                check("vec_latency", retire_latency, vt[k].elat);
                check("vec_stalls", retire_stalls, vt[k].estl);
            end
            check("vec_retired", retired_count, vt[k].eret);
            check("vec_flushed", flushed_count, vt[k].efl);
        end

        // Stall and flush together with tags 4/3 in stages 0/1.
        step(1, 0, 0, 0);
        repeat (5) step(0, 1, 0, 0);
        step(0, 1, 1, 1);
        check("sf_valid", stage_valid, 5'b11000);
        check("sf_flushed", flushed_count, 2);
        check("sf_retire_tag", retire_tag, 1);
        check("sf_stalls", retire_stalls, 0);
        step(0, 0, 0, 0);
        check("sf_next_retire", retire_tag, 2);
        check("sf_next_stalls", retire_stalls, 0);
        step(0, 1, 0, 0);
        check("sf_new_tag", stage_tag[7:0], 5);

        // Mid-stream reset discards everything.
        step(1, 1, 0, 0);
        check("mrst_valid", stage_valid, 0);
        check("mrst_cycle", cycle_count, 0);
        check("mrst_retired", retired_count, 0);
        check("mrst_flushed", flushed_count, 0);
        repeat (5) step(0, 1, 0, 0);
        check("mrst_retire_tag", retire_tag, 0);
        check("mrst_latency", retire_latency, 5);

        // Narrow tags wrap mod 8 on the second instance.
        step(1, 0, 0, 0);
        for (int s = 1; s <= 15; s++) begin
            step(0, s <= 10, 0, 0);
            if (s >= 5 && s <= 14) begin
                check("w3_retire_valid", r_valid3, 1);
                check("w3_retire_tag", r_tag3, (s - 5) % 8);
            end
        end
        check("w3_retired", ret3, 10);

        // Stall counter saturation on the narrow instance.
        step(1, 0, 0, 0);
        repeat (2) step(0, 1, 0, 0);
        repeat (6) step(0, 0, 1, 0);
        found = 0;
        for (int s = 0; s < 10 && !found; s++) begin
            step(0, 0, 0, 0);
            found = r_valid3;
        end
        check("sat_retire_seen", found, 1);
        check("sat_stalls_narrow", r_stl3, 3);
        check("sat_stalls_wide", retire_stalls, 6);

        // Random traffic against the model.
        step(1, 0, 0, 0);
        for (int s = 0; s < 1500; s++) begin
            step($urandom_range(199) == 0, $urandom_range(99) < 75,
                 $urandom_range(99) < 22, $urandom_range(99) < 8);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
